// File: rtl/dmi_access_fsm.sv
// DTM-side DMI access controller: owns the DMI data register, turns each Update-DR into one
// request towards the debug module, collects the response and keeps the sticky dmistat error.
module dmi_access_fsm #(
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned DataWidth = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              dmi_select_i,
    input  logic                              capture_i,
    input  logic                              shift_i,
    input  logic                              update_i,
    input  logic                              tdi_i,
    output logic                              tdo_o,
    input  logic                              dmireset_i,
    input  logic                              dmihardreset_i,
    output logic [1:0]                        dmistat_o,
    output logic [AddrWidth+DataWidth+1:0]    dmi_req_o,
    output logic                              dmi_req_valid_o,
    input  logic                              dmi_req_ready_i,
    input  logic [DataWidth+1:0]              dmi_resp_i,
    input  logic                              dmi_resp_valid_i,
    output logic                              dmi_resp_ready_o
);

    localparam int unsigned DrWidth = AddrWidth + DataWidth + 2;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrain
    } state_e;

    state_e                 state_q, state_d;
    logic [DrWidth-1:0]     dr_q, dr_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic [1:0]             op_q, op_d;
    logic [1:0]             error_q, error_d;
    logic                   busy;

    assign busy = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        dr_d    = dr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
        error_d = error_q;

        // TAP guarantees capture/shift/update are mutually exclusive.
        if (dmi_select_i) begin
            if (shift_i) begin
                dr_d = {tdi_i, dr_q[DrWidth-1:1]};
            end else if (capture_i) begin
                dr_d = {addr_q, data_q, (busy ? 2'b11 : error_q)};
                if (busy) begin
                    error_d = 2'b11;
                end
            end else if (update_i && (error_q == 2'b00)) begin
                if (busy) begin
                    error_d = 2'b11;
                end else if ((dr_q[1:0] == 2'b01) || (dr_q[1:0] == 2'b10)) begin
                    addr_d  = dr_q[DrWidth-1 -: AddrWidth];
                    data_d  = dr_q[DataWidth+1:2];
                    op_d    = dr_q[1:0];
                    state_d = StReq;
                end
            end
        end

        case (state_q)
            StReq: begin
                if (dmi_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dmi_resp_valid_i) begin
                    if (op_q == 2'b01) begin
                        data_d = dmi_resp_i[DataWidth+1:2];
                    end
                    if (dmi_resp_i[1:0] != 2'b00) begin
                        error_d = 2'b10;
                    end
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (dmi_resp_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: ;
        endcase

        // Hardreset acts on the post-handshake state: withdraw a pending request, and keep
        // draining a response the debug module still owes us.
        if (dmihardreset_i) begin
            error_d = 2'b00;
            if (state_d == StReq) begin
                state_d = StIdle;
            end else if (state_d == StWait) begin
                state_d = StDrain;
            end
        end

        if (dmireset_i) begin
            error_d = 2'b00;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            dr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= '0;
            error_q <= '0;
        end else begin
            state_q <= state_d;
            dr_q    <= dr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            error_q <= error_d;
        end
    end

    assign tdo_o            = dr_q[0];
    assign dmistat_o        = error_q;
    assign dmi_req_o        = {addr_q, op_q, data_q};
    assign dmi_req_valid_o  = (state_q == StReq);
    assign dmi_resp_ready_o = (state_q == StWait) || (state_q == StDrain);

endmodule

// File: tb/tb_dmi_access_fsm.sv
// Bench for dmi_access_fsm: transaction-level model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_dmi_access_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmi_select, capture, shift, update, tdi, tdo;
    logic        dmireset, dmihardreset;
    logic [1:0]  dmistat;
    logic [40:0] dmi_req;
    logic        dmi_req_valid, dmi_req_ready;
    logic [33:0] dmi_resp;
    logic        dmi_resp_valid, dmi_resp_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmi_access_fsm dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .dmi_select_i     (dmi_select),
        .capture_i        (capture),
        .shift_i          (shift),
        .update_i         (update),
        .tdi_i            (tdi),
        .tdo_o            (tdo),
        .dmireset_i       (dmireset),
        .dmihardreset_i   (dmihardreset),
        .dmistat_o        (dmistat),
        .dmi_req_o        (dmi_req),
        .dmi_req_valid_o  (dmi_req_valid),
        .dmi_req_ready_i  (dmi_req_ready),
        .dmi_resp_i       (dmi_resp),
        .dmi_resp_valid_i (dmi_resp_valid),
        .dmi_resp_ready_o (dmi_resp_ready)
    );

    // Model: request outstanding towards DM / response owed to us (kept or discarded).
    logic [40:0] m_dr, n_dr;
    logic [6:0]  m_addr, n_addr;
    logic [31:0] m_data, n_data;
    logic [1:0]  m_op, n_op, m_err, n_err;
    logic        m_req_out, n_req_out, m_resp_due, n_resp_due, m_discard, n_discard;
    logic        m_busy;

    assign m_busy = m_req_out | m_resp_due | m_discard;

    always_comb begin
        n_dr = m_dr; n_addr = m_addr; n_data = m_data; n_op = m_op; n_err = m_err;
        n_req_out = m_req_out; n_resp_due = m_resp_due; n_discard = m_discard;
        if (dmi_select && shift) begin
            n_dr = {tdi, m_dr[40:1]};
        end else if (dmi_select && capture) begin
            n_dr = {m_addr, m_data, (m_busy ? 2'd3 : m_err)};
            if (m_busy) n_err = 2'd3;
        end else if (dmi_select && update && m_err == 2'd0) begin
            if (m_busy) begin
                n_err = 2'd3;
            end else if (m_dr[1:0] == 2'd1 || m_dr[1:0] == 2'd2) begin
                n_addr = m_dr[40:34]; n_data = m_dr[33:2]; n_op = m_dr[1:0];
                n_req_out = 1'b1;
            end
        end
        if (m_req_out && dmi_req_ready) begin
            n_req_out = 1'b0; n_resp_due = 1'b1;
        end
        if (m_resp_due && dmi_resp_valid) begin
            n_resp_due = 1'b0;
            if (m_op == 2'd1) n_data = dmi_resp[33:2];
            if (dmi_resp[1:0] != 2'd0) n_err = 2'd2;
        end
        if (m_discard && dmi_resp_valid) n_discard = 1'b0;
        if (dmihardreset) begin
            n_err = 2'd0;
            n_req_out = 1'b0;
            if (n_resp_due) begin
                n_resp_due = 1'b0; n_discard = 1'b1;
            end
        end
        if (dmireset) n_err = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dr <= '0; m_addr <= '0; m_data <= '0; m_op <= '0; m_err <= '0;
            m_req_out <= 1'b0; m_resp_due <= 1'b0; m_discard <= 1'b0;
        end else begin
            m_dr <= n_dr; m_addr <= n_addr; m_data <= n_data; m_op <= n_op; m_err <= n_err;
            m_req_out <= n_req_out; m_resp_due <= n_resp_due; m_discard <= n_discard;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("tdo", 64'(tdo), 64'(m_dr[0]));
            chk("req_valid", 64'(dmi_req_valid), 64'(m_req_out));
            chk("resp_ready", 64'(dmi_resp_ready), 64'(m_resp_due | m_discard));
            chk("dmistat", 64'(dmistat), 64'(m_err));
            if (m_req_out) chk("req_payload", 64'(dmi_req), 64'({m_addr, m_op, m_data}));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic shift_dr(input logic [40:0] v);
        for (int i = 0; i < 41; i++) begin
            dmi_select = 1'b1; shift = 1'b1; tdi = v[i];
            tick();
        end
        shift = 1'b0; tdi = 1'b0;
    endtask

    task automatic read_dr(output logic [40:0] v);
        for (int i = 0; i < 41; i++) begin
            v[i] = tdo; shift = 1'b1; tdi = 1'b0;
            tick();
        end
        shift = 1'b0;
    endtask

    task automatic capture_dr();
        capture = 1'b1; tick(); capture = 1'b0;
    endtask

    task automatic pulse_update();
        update = 1'b1; tick(); update = 1'b0;
    endtask

    task automatic do_update(input logic [40:0] v);
        shift_dr(v); pulse_update();
    endtask

    task automatic pulse_dmireset();
        dmireset = 1'b1; tick(); dmireset = 1'b0;
    endtask

    task automatic pulse_hardreset();
        dmihardreset = 1'b1; tick(); dmihardreset = 1'b0;
    endtask

    task automatic accept_req();
        logic acc;
        acc = 1'b0;
        dmi_req_ready = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = dmi_req_valid; tick();
        end
        dmi_req_ready = 1'b0;
        if (!acc) chk("req_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic give_resp(input logic [31:0] d, input logic [1:0] r);
        logic acc;
        acc = 1'b0;
        dmi_resp = {d, r}; dmi_resp_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = dmi_resp_ready; tick();
        end
        dmi_resp_valid = 1'b0; dmi_resp = '0;
        if (!acc) chk("resp_accept_timeout", 64'(acc), 64'd1);
    endtask

    logic [40:0] v;

    initial begin
        rst_n = 1'b0; dmi_select = 1'b1; capture = 1'b0; shift = 1'b0; update = 1'b0;
        tdi = 1'b0; dmireset = 1'b0; dmihardreset = 1'b0; dmi_req_ready = 1'b0;
        dmi_resp = '0; dmi_resp_valid = 1'b0;
        #2;
        chk("rst_valid", 64'(dmi_req_valid), 64'd0);
        chk("rst_tdo", 64'(tdo), 64'd0);
        chk("rst_dmistat", 64'(dmistat), 64'd0);
        chk("rst_resp_ready", 64'(dmi_resp_ready), 64'd0);
        #10 rst_n = 1'b1;
        tick();

        // Write
        do_update({7'h10, 32'h0000_0001, 2'd2});
        chk("wr_valid", 64'(dmi_req_valid), 64'd1);
        chk("wr_req", 64'(dmi_req), 64'({7'h10, 2'd2, 32'h0000_0001}));
        chk("wr_model", 64'({m_addr, m_op, m_data}), 64'({7'h10, 2'd2, 32'h0000_0001}));
        tick(); tick();
        chk("wr_hold", 64'(dmi_req_valid), 64'd1);
        accept_req();
        chk("wr_wait_ready", 64'(dmi_resp_ready), 64'd1);
        give_resp(32'h0, 2'd0);
        chk("wr_idle_ready", 64'(dmi_resp_ready), 64'd0);
        capture_dr();
        read_dr(v);
        chk("wr_capture", 64'(v), 64'({7'h10, 32'h0000_0001, 2'd0}));

        // Read
        do_update({7'h11, 32'h0, 2'd1});
        accept_req();
        give_resp(32'h0040_0382, 2'd0);
        capture_dr();
        read_dr(v);
        chk("rd_capture", 64'(v), 64'({7'h11, 32'h0040_0382, 2'd0}));

        // Update with the DMI register not selected does nothing
        shift_dr({7'h15, 32'h5, 2'd2});
        dmi_select = 1'b0; pulse_update(); dmi_select = 1'b1;
        chk("nosel_valid", 64'(dmi_req_valid), 64'd0);

        // Busy
        do_update({7'h12, 32'h0000_CAFE, 2'd2});
        capture_dr();
        chk("busy_tdo", 64'(tdo), 64'd1);
        chk("busy_stat", 64'(dmistat), 64'd3);
        read_dr(v);
        chk("busy_capture", 64'(v), 64'({7'h12, 32'h0000_CAFE, 2'd3}));
        do_update({7'h20, 32'h0000_0099, 2'd2});
        chk("busy_req_kept", 64'(dmi_req), 64'({7'h12, 2'd2, 32'h0000_CAFE}));
        pulse_dmireset();
        chk("busy_clr", 64'(dmistat), 64'd0);
        pulse_update();
        chk("busy_upd_err", 64'(dmistat), 64'd3);
        pulse_dmireset();
        accept_req();
        give_resp(32'h0, 2'd0);
        pulse_update();
        chk("busy_after_req", 64'(dmi_req), 64'({7'h20, 2'd2, 32'h0000_0099}));
        accept_req();
        give_resp(32'h0, 2'd0);

        // Failure
        do_update({7'h13, 32'h0, 2'd1});
        accept_req();
        give_resp(32'h0000_1234, 2'd2);
        chk("fail_stat", 64'(dmistat), 64'd2);
        do_update({7'h21, 32'h55AA_55AA, 2'd2});
        tick();
        chk("fail_ignored", 64'(dmi_req_valid), 64'd0);
        pulse_dmireset();
        chk("fail_clr", 64'(dmistat), 64'd0);
        pulse_update();
        chk("fail_retry", 64'(dmi_req), 64'({7'h21, 2'd2, 32'h55AA_55AA}));
        accept_req();
        give_resp(32'h0, 2'd0);

        // Hardreset in WAIT drains and discards
        do_update({7'h14, 32'h0BAD_F00D, 2'd1});
        accept_req();
        pulse_hardreset();
        chk("hr_drain_ready", 64'(dmi_resp_ready), 64'd1);
        give_resp(32'hDEAD_BEEF, 2'd2);
        chk("hr_stat", 64'(dmistat), 64'd0);
        chk("hr_idle", 64'(dmi_resp_ready), 64'd0);
        capture_dr();
        read_dr(v);
        chk("hr_capture", 64'(v), 64'({7'h14, 32'h0BAD_F00D, 2'd0}));

        // Hardreset in REQ withdraws the request
        do_update({7'h16, 32'h0000_0077, 2'd2});
        chk("hr_req_valid", 64'(dmi_req_valid), 64'd1);
        pulse_hardreset();
        chk("hr_req_drop", 64'(dmi_req_valid), 64'd0);

        // Async reset mid-REQ
        do_update({7'h17, 32'h0000_0001, 2'd2});
        capture_dr();
        chk("ar_pre_stat", 64'(dmistat), 64'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(dmi_req_valid), 64'd0);
        chk("ar_tdo", 64'(tdo), 64'd0);
        chk("ar_stat", 64'(dmistat), 64'd0);
        dmi_resp = {32'h1111_2222, 2'd0}; dmi_resp_valid = 1'b1;
        #3 rst_n = 1'b1;
        tick(); tick();
        chk("ar_resp_ignored", 64'(dmi_resp_ready), 64'd0);
        dmi_resp_valid = 1'b0;
        tick();

        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmi_access_fsm.md
Name: dmi_access_fsm

Overview:
- DTM-side DMI access controller. Sits between the JTAG TAP/dtmcs logic and the DMI request/response path into the debug module (CDC, then dm_csrs).
- Owns the 41-bit DMI data register: capture, shift, update. Turns each update into one request of `{addr[6:0], op[1:0], data[31:0]}`, collects the response, and keeps the sticky dmistat error that dtmcs reports.

Parameters:
- AddrWidth, 7, DMI address width.
- DataWidth, 32, DMI data width. The DR is AddrWidth+DataWidth+2 bits = 41.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dmi_select_i  in  1  IR currently selects the DMI register
- capture_i  in  1  Capture-DR pulse
- shift_i  in  1  Shift-DR enable
- update_i  in  1  Update-DR pulse
- tdi_i  in  1  serial data in
- tdo_o  out  1  serial data out, = dr_q[0]
- dmireset_i  in  1  dtmcs.dmireset pulse
- dmihardreset_i  in  1  dtmcs.dmihardreset pulse
- dmistat_o  out  2  sticky error: 0 ok, 2 failed, 3 busy
- dmi_req_o  out  41  `{addr, op, data}`
- dmi_req_valid_o  out  1  request valid
- dmi_req_ready_i  in  1  request accepted
- dmi_resp_i  in  34  `{data[31:0], resp[1:0]}`
- dmi_resp_valid_i  in  1  response valid
- dmi_resp_ready_o  out  1  ready for response

Behaviour:
- **Reset:** dr_q, addr_q, data_q, op_q, error_q all 0. State IDLE. tdo_o=0, dmi_req_valid_o=0, dmi_resp_ready_o=0, dmistat_o=0.
- **DR layout:** `dr[1:0]=op`, `dr[33:2]=data`, `dr[40:34]=addr`.
- **Shift** (dmi_select_i & shift_i): `dr <= {tdi_i, dr[40:1]}`. LSB leaves first.
- **Capture** (dmi_select_i & capture_i): `dr <= {addr_q, data_q, opfield}`.
  - opfield = 3 if state != IDLE; otherwise error_q.
  - Capturing while state != IDLE also sets error_q=3.
- **Update** (dmi_select_i & update_i): ignored if error_q != 0.
  - If state != IDLE: error_q <= 3 and the request is dropped.
  - Else if dr op is 1 (read) or 2 (write): latch addr_q, data_q, op_q from dr and go to REQ.
  - Op 0 (nop) and op 3 (reserved): no action.
- **States:** IDLE, REQ, WAIT, DRAIN.
  - REQ: dmi_req_valid_o=1, dmi_req_o held stable from `{addr_q, op_q, data_q}`. On dmi_req_ready_i go to WAIT (same-cycle accept allowed).
  - WAIT: dmi_resp_ready_o=1. On dmi_resp_valid_i:
    - If op_q=read, data_q <= resp.data.
    - If resp.resp != 0, error_q <= 2.
    - Go to IDLE.
  - DRAIN: dmi_resp_ready_o=1. On dmi_resp_valid_i, discard the response and go to IDLE.
  - A response arriving outside WAIT/DRAIN is not accepted (ready=0).
- **dmireset_i:** error_q <= 0. Wins over any same-cycle error set. No effect on state.
- **dmihardreset_i:** error_q <= 0.
  - REQ: go to IDLE and drop valid. Downstream CDC tolerates withdrawal.
  - WAIT: go to DRAIN.
  - IDLE and DRAIN: unchanged.
  - Priority over a same-cycle update/handshake: handshake completes first, then the hardreset rule applies to the next state.
- **Latency:** update → dmi_req_valid_o is 1 cycle. Response → state IDLE is 1 cycle. Capture in the cycle after IDLE is reached reports the new status.
- **Simultaneous events:** capture, shift and update are mutually exclusive by TAP construction; behaviour when more than one is asserted is undefined.
- **dmistat_o** = error_q, registered.
- **Reset mid-operation:** everything returns to reset values asynchronously. Any in-flight response after reset is not accepted.

Test Plan:
- **Write:** shift addr=0x10, data=0x00000001, op=2; update → next cycle dmi_req_o=`{0x10,2,0x00000001}`, valid=1. Ready after 2 cycles → WAIT. resp=0 → IDLE. Capture → dr[1:0]=0.
- **Read:** shift addr=0x11, op=1; update. Response data=0x00400382, resp=0 → capture and shift out 41 bits: op=0, data=0x00400382, addr=0x11.
- **Busy:** update write, hold ready=0. Capture → op=3 and dmistat_o=3. A second update issues no request. dmireset_i → dmistat_o=0. After completion a new update issues a request.
- **Failure:** read returns resp=2 → dmistat_o=2. Next update is ignored (valid stays 0). dmireset_i clears it and the following update proceeds.
- **Hardreset:** in WAIT pulse dmihardreset_i → DRAIN. Response data=0xDEADBEEF is discarded; data_q is unchanged, dmistat_o=0, state IDLE. In REQ, hardreset drops valid the next cycle.
- **Async reset:** assert rst_ni low mid-REQ → valid=0, tdo_o=0, dmistat_o=0 immediately.
